// File: rtl/pixel_stream_src_pkg.sv
// Shared definitions for the raster pixel source and the window generator stage:
// FSM encoding, read-pipeline tag and default image geometry.
package pixel_stream_src_pkg;

    localparam int DEF_DW     = 8;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_AW     = 21;
    localparam int DEF_HBLANK = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBL    = 2'd2,
        ST_DRAIN  = 2'd3
    } src_state_t;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
        logic eof;
    } pix_tag_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_src_raster_cnt.sv
// Column/row raster counter with line wrap and first/last position flags.
// Shared with the window stage, which walks the same raster.
module raster_cnt
    import pixel_stream_src_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    output logic first_pix,
    output logic last_col,
    output logic last_row
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (last_col) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    assign last_col  = (col == CW'(IMG_W - 1));
    assign last_row  = (row == RW'(IMG_H - 1));
    assign first_pix = (col == '0) && (row == '0);

endmodule

// File: rtl/pixel_stream_src.sv
// Raster pixel source: reads one frame from a synchronous RAM in raster order and
// emits a registered pixel stream with sof/eol/eof markers and optional h-blanking.
module pixel_stream_src
    import pixel_stream_src_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int HBLANK = DEF_HBLANK,
    parameter int AW     = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          sof,
    output logic          eol,
    output logic          eof,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pix_cnt
);

    localparam int HB_W    = cnt_w((HBLANK > 0) ? HBLANK : 1);
    localparam int HB_LAST = (HBLANK > 0) ? HBLANK - 1 : 0;

    src_state_t state, state_nxt;
    pix_tag_t   tag_nxt, rd_tag, s1_tag;
    logic [HB_W-1:0] hb_cnt;
    logic [AW-1:0]   rd_addr;
    logic clr, step, busy_nxt, done_nxt;
    logic first_pix, last_col, last_row;

    raster_cnt #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .step     (step),
        .first_pix(first_pix),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_comb begin
        state_nxt = state;
        tag_nxt   = '0;
        clr       = 1'b0;
        step      = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // The done cycle is still part of the previous frame.
                if (start && !done) begin
                    state_nxt = ST_ACTIVE;
                    clr       = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                step        = 1'b1;
                tag_nxt.vld = 1'b1;
                tag_nxt.sof = first_pix;
                tag_nxt.eol = last_col;
                tag_nxt.eof = last_col && last_row;
                if (last_col) begin
                    if (last_row)
                        state_nxt = ST_DRAIN;
                    else if (HBLANK > 0)
                        state_nxt = ST_HBL;
                end
            end
            ST_HBL: begin
                if (hb_cnt == HB_W'(HB_LAST))
                    state_nxt = ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (dout_valid && eof) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            hb_cnt     <= '0;
            rd_addr    <= '0;
            rd_tag     <= '0;
            s1_tag     <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            pix_cnt    <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            hb_cnt <= (state == ST_HBL) ? hb_cnt + HB_W'(1) : '0;

            // Linear address tracks row*IMG_W+col without a multiplier.
            if (clr)
                rd_addr <= '0;
            else if (tag_nxt.vld)
                rd_addr <= rd_addr + AW'(1);

            mem_rd <= tag_nxt.vld;
            if (tag_nxt.vld)
                mem_addr <= rd_addr;

            // Tags ride alongside the read so markers line up with RAM data.
            rd_tag     <= tag_nxt;
            s1_tag     <= rd_tag;
            dout_valid <= s1_tag.vld;
            sof        <= s1_tag.sof;
            eol        <= s1_tag.eol;
            eof        <= s1_tag.eof;
            if (s1_tag.vld)
                dout <= mem_rdata;

            if (clr)
                pix_cnt <= '0;
            else if (s1_tag.vld)
                pix_cnt <= pix_cnt + AW'(1);
        end
    end

endmodule

// File: tb/tb_pixel_stream_src.sv
// Scoreboard bench for pixel_stream_src: three instances (4x3 hblank 2, 4x3 no blank,
// 2x2 no blank) fed by a RAM model returning address[7:0].
module tb_pixel_stream_src;

    localparam int AW = 21;
    localparam int ND = 3;

    function automatic int w_of(input int d);
        return (d == 2) ? 2 : 4;
    endfunction
    function automatic int h_of(input int d);
        return (d == 2) ? 2 : 3;
    endfunction
    function automatic int hb_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    typedef struct {
        int d;
        int cyc;
        int pix;
        int mark;
        int cnt;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst        [ND];
    logic          start      [ND];
    logic          mem_rd     [ND];
    logic [AW-1:0] mem_addr   [ND];
    logic [7:0]    mem_rdata  [ND];
    logic [7:0]    dout       [ND];
    logic          dout_valid [ND];
    logic          sof        [ND];
    logic          eol        [ND];
    logic          eof        [ND];
    logic          busy       [ND];
    logic          done       [ND];
    logic [AW-1:0] pix_cnt    [ND];

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  exp_done [ND];
    sb_t sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        pixel_stream_src #(
            .DW(8), .IMG_W(w_of(g)), .IMG_H(h_of(g)), .HBLANK(hb_of(g)), .AW(AW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .start     (start[g]),
            .mem_rd    (mem_rd[g]),
            .mem_addr  (mem_addr[g]),
            .mem_rdata (mem_rdata[g]),
            .dout      (dout[g]),
            .dout_valid(dout_valid[g]),
            .sof       (sof[g]),
            .eol       (eol[g]),
            .eof       (eof[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pix_cnt   (pix_cnt[g])
        );
    end

    always @(posedge clk)
        for (int d = 0; d < ND; d++)
            if (mem_rd[d]) mem_rdata[d] <= mem_addr[d][7:0];

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per valid pixel, checks done timing.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (dout_valid[d]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pixel", int'(dout[d]), -1);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("pix_dut", d, e.d);
                    chk("pix_data", int'(dout[d]), e.pix);
                    chk("pix_cycle", cyc, e.cyc);
                    chk("pix_markers", int'({sof[d], eol[d], eof[d]}), e.mark);
                    chk("pix_cnt", int'(pix_cnt[d]), e.cnt);
                end
            end else if (rst[d]) begin
                chk("idle_markers", int'({sof[d], eol[d], eof[d]}), 0);
            end
            if (done[d]) begin
                chk("done_cycle", cyc, exp_done[d]);
                chk("done_busy", int'(busy[d]), 0);
                chk("done_pix_cnt", int'(pix_cnt[d]), w_of(d) * h_of(d));
            end
        end
    end

    // Hand-derived expectations: pixel k leaves 3 edges after the start edge,
    // plus one cycle per pixel and HBLANK cycles per completed line.
    task automatic push_frame(input int d, input int sedge);
        int w, h, last;
        w = w_of(d);
        h = h_of(d);
        last = 0;
        for (int k = 0; k < w * h; k++) begin
            sb_t e;
            e.d    = d;
            e.cyc  = sedge + 3 + k + (k / w) * hb_of(d);
            e.pix  = k;
            e.mark = {k == 0, (k % w) == w - 1, k == w * h - 1};
            e.cnt  = k + 1;
            last   = e.cyc;
            sbq.push_back(e);
        end
        exp_done[d] = last + 1;
    endtask

    task automatic start_frame(input int d);
        @(negedge clk) start[d] = 1'b1;
        @(negedge clk) start[d] = 1'b0;
        push_frame(d, cyc);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[d] && n < 200);
        if (!done[d]) chk("timeout_done", int'(done[d]), 1);
    endtask

    task automatic wait_pix(input int d, input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dout_valid[d] && int'(dout[d]) == v) && n < 200);
        if (!(dout_valid[d] && int'(dout[d]) == v)) chk("timeout_pix", int'(dout[d]), v);
    endtask

    task automatic chk_zero(input int d);
        chk("zero_flags", int'({mem_rd[d], dout_valid[d], sof[d], eol[d], eof[d], busy[d], done[d]}), 0);
        chk("zero_addr", int'(mem_addr[d]), 0);
        chk("zero_dout", int'(dout[d]), 0);
        chk("zero_pix_cnt", int'(pix_cnt[d]), 0);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b0;
            start[d] = 1'b0;
            exp_done[d] = -1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) chk_zero(d);
        for (int d = 0; d < ND; d++) rst[d] = 1'b1;

        // 4x3 with two blank cycles per line; pix_cnt holds after done.
        start_frame(0);
        wait_done(0);
        @(negedge clk);
        chk("pix_cnt_hold", int'(pix_cnt[0]), 12);
        chk("busy_after_done", int'(busy[0]), 0);

        // Continuous stream, no gaps.
        start_frame(1);
        wait_done(1);

        // Re-pulse of start while busy has no effect.
        start_frame(0);
        wait_pix(0, 5);
        start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        wait_done(0);

        // Mid-frame reset aborts: everything zero, no eof/done afterwards.
        start_frame(0);
        wait_pix(0, 6);
        rst[0] = 1'b0;
        exp_done[0] = -1;
        @(negedge clk);
        sbq.delete();
        chk_zero(0);
        rst[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_abort_busy", int'(busy[0]), 0);
        start_frame(0);
        wait_done(0);

        // Back-to-back: start held through the done cycle, taken the cycle after.
        start[0] = 1'b1;
        @(negedge clk);
        @(negedge clk) start[0] = 1'b0;
        push_frame(0, cyc);
        wait_done(0);

        // Minimum 2x2 frame.
        start_frame(2);
        wait_done(2);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
